lc3_dsr_tx_bridge: RTL and testbench

Parametrised display-output bridge between the LC-3 memory-mapped display registers (DDR/DSR) and a uart_tx instance. It replaces the single-character output handshake with a FIFO-buffered queue, so the CPU can write several characters without polling per byte. The FIFO is drained one byte at a time through the uart_tx DV/Done handshake. The DSR ready bit is derived from FIFO occupancy.

---
 rtl/lc3_dsr_tx_bridge.sv | 188 ++++++++++++++++++
 tb/tb_lc3_dsr_tx_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_dsr_tx_bridge.sv
// lc3_dsr_tx_bridge: buffers LC-3 DDR writes in a small FIFO and drains them
// one character at a time through the uart_tx DV/Done handshake. DSR ready
// reflects whether the FIFO can take another character.
// Optional build macro LF_TO_CRLF_EN: expand each LF into CR, LF on the wire.
module lc3_dsr_tx_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Ddr_Wr,
  input  logic [15:0]           i_Ddr_Data,
  input  logic                  i_Tx_Done,
  output logic                  o_Tx_DV,
  output logic [DATA_WIDTH-1:0] o_Tx_Byte,
  output logic [15:0]           o_Dsr,
  output logic                  o_Ld_Dsr,
  output logic [CNT_W-1:0]      o_Fifo_Count,
  output logic                  o_Overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] wr_char;
  logic [DATA_WIDTH-1:0] byte_next;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  pop;
  logic                  push;
  logic                  load_byte;
  logic                  overflow;
  logic                  dsr_rdy;
  logic                  rdy_next;
  logic                  ld_dsr;
  logic                  unused_ddr_hi;

`ifdef LF_TO_CRLF_EN
  localparam logic [7:0] LF8 = 8'h0A;
  localparam logic [7:0] CR8 = 8'h0D;
  localparam logic [DATA_WIDTH-1:0] LF_CHAR = LF8[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] CR_CHAR = CR8[DATA_WIDTH-1:0];
  logic cr_sent;
  logic insert_cr;
`endif

  // Upper DDR bits carry nothing for the display path.
  assign unused_ddr_hi = ^i_Ddr_Data[15:DATA_WIDTH];
  assign wr_char       = i_Ddr_Data[DATA_WIDTH-1:0];
  assign head          = mem[rd_ptr];

  // A write into a full FIFO still fits if the head leaves in the same cycle.
  assign push       = i_Ddr_Wr && ((count != FULL_CNT) || pop);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign rdy_next   = (count_next != FULL_CNT);

  // Next-state and handshake decode; the DV pulse is the SEND state itself.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_byte  = 1'b0;
    byte_next  = head;
    o_Tx_DV    = 1'b0;
`ifdef LF_TO_CRLF_EN
    insert_cr  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          load_byte  = 1'b1;
          state_next = S_SEND;
`ifdef LF_TO_CRLF_EN
          // CR goes out first while the LF stays queued for the next round.
          if ((head == LF_CHAR) && !cr_sent) begin
            insert_cr = 1'b1;
            byte_next = CR_CHAR;
          end else begin
            pop = 1'b1;
          end
`else
          pop = 1'b1;
`endif
        end
      end
      S_SEND: begin
        o_Tx_DV    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FIFO storage; contents need no reset because occupancy guards every read.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_char;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      if (i_Ddr_Wr && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // Character register presented to uart_tx, held until the next load.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      tx_byte <= '0;
    end else if (load_byte) begin
      tx_byte <= byte_next;
    end
  end

  // DSR ready bit tracks next occupancy; load strobe fires on each change.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dsr_rdy <= 1'b1;
      ld_dsr  <= 1'b0;
    end else begin
      dsr_rdy <= rdy_next;
      ld_dsr  <= (rdy_next != dsr_rdy);
    end
  end

`ifdef LF_TO_CRLF_EN
  // Remembers that the CR for the queued LF has already gone out.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cr_sent <= 1'b0;
    end else if (insert_cr) begin
      cr_sent <= 1'b1;
    end else if (pop) begin
      cr_sent <= 1'b0;
    end
  end
`endif

  assign o_Tx_Byte    = tx_byte;
  assign o_Dsr        = {dsr_rdy, 15'b0};
  assign o_Ld_Dsr     = ld_dsr;
  assign o_Fifo_Count = count;
  assign o_Overflow   = overflow;

endmodule

// File: tb/tb_lc3_dsr_tx_bridge.sv
// Directed bench for lc3_dsr_tx_bridge at default parameters.
// Expected CR/LF behaviour follows the LF_TO_CRLF_EN build macro.
module tb_lc3_dsr_tx_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ddr_wr = 1'b0;
  logic [15:0] ddr_data = 16'h0000;
  logic        tx_done = 1'b0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [15:0] dsr;
  logic        ld_dsr;
  logic [2:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lc3_dsr_tx_bridge #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(4)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Ddr_Wr    (ddr_wr),
    .i_Ddr_Data  (ddr_data),
    .i_Tx_Done   (tx_done),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .o_Dsr       (dsr),
    .o_Ld_Dsr    (ld_dsr),
    .o_Fifo_Count(fifo_count),
    .o_Overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int ld_seen;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (dsr !== 16'h8000) begin failures++; $display("FAIL reset_dsr got=%h exp=8000", dsr); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", tx_dv); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_byte got=%h exp=00", tx_byte); end
    rst_n = 1'b1;
    ld_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ld_dsr === 1'b1) ld_seen++;
    end
    checks++; if (ld_seen !== 0) begin failures++; $display("FAIL reset_release_ld got=%0d pulses exp=0", ld_seen); end
  endtask

  task automatic test_single();
    int dv_seen;
    ddr_data = 16'h0058;
    ddr_wr = 1'b1;
    tick();
    ddr_wr = 1'b0;
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count_n1 got=%0d exp=1", fifo_count); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL single_dv_n1 got=%b exp=0", tx_dv); end
    tick();
    checks++; if (tx_dv !== 1'b1) begin failures++; $display("FAIL single_dv_n2 got=%b exp=1", tx_dv); end
    checks++; if (tx_byte !== 8'h58) begin failures++; $display("FAIL single_byte got=%h exp=58", tx_byte); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_count_n2 got=%0d exp=0", fifo_count); end
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_dv === 1'b1) dv_seen++;
      checks++; if (tx_byte !== 8'h58) begin failures++; $display("FAIL single_hold got=%h exp=58", tx_byte); end
    end
    checks++; if (dv_seen !== 0) begin failures++; $display("FAIL single_dv_once got=%0d extra exp=0", dv_seen); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    // stray completion while idle with nothing queued
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_dv === 1'b1) dv_seen++;
    end
    checks++; if (dv_seen !== 0) begin failures++; $display("FAIL stray_done_dv got=%0d exp=0", dv_seen); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL stray_done_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_fill_overflow();
    ddr_wr = 1'b1;
    ddr_data = 16'h0041;
    tick();
    ddr_data = 16'h0042;
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL fill_count_1 got=%0d exp=1", fifo_count); end
    tick();
    ddr_data = 16'h0043;
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h41) begin failures++; $display("FAIL fill_first_dv got=%b/%h exp=1/41", tx_dv, tx_byte); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL fill_count_pushpop got=%0d exp=1", fifo_count); end
    tick();
    ddr_data = 16'h0044;
    checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL fill_count_2 got=%0d exp=2", fifo_count); end
    tick();
    ddr_data = 16'h0045;
    checks++; if (fifo_count !== 3'd3 || dsr !== 16'h8000) begin failures++; $display("FAIL fill_count_3 got=%0d/%h exp=3/8000", fifo_count, dsr); end
    tick();
    ddr_data = 16'h0046;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count_4 got=%0d exp=4", fifo_count); end
    checks++; if (dsr !== 16'h0000) begin failures++; $display("FAIL fill_dsr_full got=%h exp=0000", dsr); end
    checks++; if (ld_dsr !== 1'b1) begin failures++; $display("FAIL fill_ld_pulse got=%b exp=1", ld_dsr); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_no_overflow_yet got=%b exp=0", overflow); end
    tick();
    ddr_wr = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL fill_count_after_drop got=%0d exp=4", fifo_count); end
    checks++; if (ld_dsr !== 1'b0) begin failures++; $display("FAIL fill_ld_one_cycle got=%b exp=0", ld_dsr); end
    tick();
  endtask

  task automatic test_drain();
    logic [7:0] exp_bytes [5];
    int ld_seen;
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43;
    exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h45;
    ld_seen = 0;
    checks++; if (tx_byte !== exp_bytes[0]) begin failures++; $display("FAIL drain_byte0 got=%h exp=41", tx_byte); end
    for (int i = 0; i < 4; i++) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (ld_dsr === 1'b1) ld_seen++;
      checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL drain_dv_early%0d got=%b exp=0", i, tx_dv); end
      tick();
      if (ld_dsr === 1'b1) ld_seen++;
      checks++; if (tx_dv !== 1'b1 || tx_byte !== exp_bytes[i+1]) begin failures++; $display("FAIL drain_byte%0d got=%b/%h exp=1/%h", i+1, tx_dv, tx_byte, exp_bytes[i+1]); end
      if (i == 0) begin
        checks++; if (dsr !== 16'h8000 || ld_dsr !== 1'b1) begin failures++; $display("FAIL drain_dsr_ready got=%h/%b exp=8000/1", dsr, ld_dsr); end
      end
      tick();
      if (ld_dsr === 1'b1) ld_seen++;
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    tick();
    checks++; if (fifo_count !== 3'd0 || tx_dv !== 1'b0) begin failures++; $display("FAIL drain_final got=%0d/%b exp=0/0", fifo_count, tx_dv); end
    checks++; if (ld_seen !== 1) begin failures++; $display("FAIL drain_ld_count got=%0d exp=1", ld_seen); end
  endtask

  task automatic test_back_to_back_push_pop();
    logic [7:0] exp_bytes [4];
    exp_bytes[0] = 8'h53; exp_bytes[1] = 8'h54; exp_bytes[2] = 8'h55; exp_bytes[3] = 8'h56;
    do_reset();
    ddr_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ddr_data = 16'h0051 + 16'(i);
      tick();
    end
    ddr_wr = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pp_prefill got=%0d exp=4", fifo_count); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    ddr_wr = 1'b1;
    ddr_data = 16'h0056;
    tick();
    ddr_wr = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL pp_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_overflow got=%b exp=0", overflow); end
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h52) begin failures++; $display("FAIL pp_byte got=%b/%h exp=1/52", tx_dv, tx_byte); end
    checks++; if (dsr !== 16'h0000 || ld_dsr !== 1'b0) begin failures++; $display("FAIL pp_dsr got=%h/%b exp=0000/0", dsr, ld_dsr); end
    tick();
    for (int i = 0; i < 4; i++) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      checks++; if (tx_dv !== 1'b1 || tx_byte !== exp_bytes[i]) begin failures++; $display("FAIL pp_drain%0d got=%b/%h exp=1/%h", i, tx_dv, tx_byte, exp_bytes[i]); end
      tick();
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    tick();
    checks++; if (fifo_count !== 3'd0 || tx_dv !== 1'b0) begin failures++; $display("FAIL pp_final got=%0d/%b exp=0/0", fifo_count, tx_dv); end
  endtask

  task automatic test_lf();
    ddr_data = 16'h000A;
    ddr_wr = 1'b1;
    tick();
    ddr_wr = 1'b0;
    tick();
`ifdef LF_TO_CRLF_EN
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h0D) begin failures++; $display("FAIL lf_cr got=%b/%h exp=1/0D", tx_dv, tx_byte); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL lf_cr_count got=%0d exp=1", fifo_count); end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h0A) begin failures++; $display("FAIL lf_lf got=%b/%h exp=1/0A", tx_dv, tx_byte); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL lf_lf_count got=%0d exp=0", fifo_count); end
`else
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h0A) begin failures++; $display("FAIL lf_verbatim got=%b/%h exp=1/0A", tx_dv, tx_byte); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL lf_count got=%0d exp=0", fifo_count); end
`endif
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    tick();
    checks++; if (tx_dv !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL lf_single_round got=%b/%0d exp=0/0", tx_dv, fifo_count); end
  endtask

  task automatic test_reset_in_wait();
    int dv_seen;
    ddr_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ddr_data = 16'h0077 + 16'(i);
      tick();
    end
    ddr_wr = 1'b0;
    checks++; if (overflow !== 1'b1 || tx_byte !== 8'h77 || dsr !== 16'h0000) begin failures++; $display("FAIL rw_precond got=%b/%h/%h exp=1/77/0000", overflow, tx_byte, dsr); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin failures++; $display("FAIL rw_tx got=%b/%h exp=0/00", tx_dv, tx_byte); end
    checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0) begin failures++; $display("FAIL rw_fifo got=%0d/%b exp=0/0", fifo_count, overflow); end
    checks++; if (dsr !== 16'h8000 || ld_dsr !== 1'b0) begin failures++; $display("FAIL rw_dsr got=%h/%b exp=8000/0", dsr, ld_dsr); end
    tick();
    rst_n = 1'b1;
    // completion of the pre-reset transfer arrives late
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tx_dv === 1'b1) dv_seen++;
    end
    checks++; if (dv_seen !== 0 || fifo_count !== 3'd0) begin failures++; $display("FAIL rw_after got=%0d/%0d exp=0/0", dv_seen, fifo_count); end
    ddr_data = 16'h0031;
    ddr_wr = 1'b1;
    tick();
    ddr_wr = 1'b0;
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_byte !== 8'h31) begin failures++; $display("FAIL rw_resume got=%b/%h exp=1/31", tx_dv, tx_byte); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_drain();
    test_back_to_back_push_pop();
    test_lf();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
